// File: rtl/cam_ctrl.sv
// cam_ctrl: single-requester sequencer for a read/write/search CAM array.
// Optional hit/miss counters are compiled in when CAM_CTRL_STATS_EN is defined.
module cam_ctrl #(
  parameter int ARRAY_WIDTH_LOG2 = 5,
  parameter int ARRAY_SIZE_LOG2  = 5,
  localparam int DATA_W = 2 ** ARRAY_WIDTH_LOG2,
  localparam int IDX_W  = ARRAY_SIZE_LOG2
) (
  input  logic              clk,
  input  logic              reset_i,
  // command channel
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [IDX_W-1:0]  req_index_i,
  input  logic [DATA_W-1:0] req_data_i,
  // response channel
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_hit_o,
  output logic [IDX_W-1:0]  rsp_index_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_evict_o,
  output logic              rsp_err_o,
  output logic              full_o,
  // CAM datapath
  output logic              cam_read_o,
  output logic [IDX_W-1:0]  cam_read_index_o,
  output logic              cam_write_o,
  output logic [IDX_W-1:0]  cam_write_index_o,
  output logic [DATA_W-1:0] cam_write_data_o,
  output logic              cam_search_o,
  output logic [DATA_W-1:0] cam_search_data_o,
  input  logic              cam_read_valid_i,
  input  logic [DATA_W-1:0] cam_read_value_i,
  input  logic              cam_search_valid_i,
  input  logic [IDX_W-1:0]  cam_search_index_i
`ifdef CAM_CTRL_STATS_EN
  ,
  input  logic              stat_clr_i,
  output logic [15:0]       stat_hits_o,
  output logic [15:0]       stat_misses_o
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_SEARCH = 2'b01;
  localparam logic [1:0] OP_INSERT = 2'b10;

  localparam logic [IDX_W:0] SLOTS = {1'b1, {IDX_W{1'b0}}};

  logic [1:0]        state_reg, state_next;
  logic [1:0]        op_reg, op_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [DATA_W-1:0] key_reg, key_next;

  logic              rsp_hit_reg, rsp_hit_next;
  logic [IDX_W-1:0]  rsp_index_reg, rsp_index_next;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
  logic              rsp_evict_reg, rsp_evict_next;
  logic              rsp_err_reg, rsp_err_next;

  logic [IDX_W-1:0]  alloc_ptr_reg, alloc_ptr_next;
  logic [IDX_W:0]    alloc_cnt_reg, alloc_cnt_next;
  logic              full;

  logic [DATA_W-1:0] read_gated;
  logic              is_search_op;

  assign full         = (alloc_cnt_reg == SLOTS);
  assign is_search_op = (op_reg == OP_SEARCH) || (op_reg == OP_INSERT);

  // A read of an invalid entry must report zero data, whatever the array holds.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_read_gate
      assign read_gated[gi] = cam_read_value_i[gi] & cam_read_valid_i;
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    idx_next       = idx_reg;
    key_next       = key_reg;
    rsp_hit_next   = rsp_hit_reg;
    rsp_index_next = rsp_index_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_evict_next = rsp_evict_reg;
    rsp_err_next   = rsp_err_reg;
    alloc_ptr_next = alloc_ptr_reg;
    alloc_cnt_next = alloc_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          op_next    = req_op_i;
          idx_next   = req_index_i;
          key_next   = req_data_i;
          state_next = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        rsp_hit_next   = 1'b0;
        rsp_index_next = '0;
        rsp_data_next  = '0;
        rsp_evict_next = 1'b0;
        rsp_err_next   = 1'b0;
        state_next     = ST_RESP;
        case (op_reg)
          OP_READ: begin
            rsp_hit_next   = cam_read_valid_i;
            rsp_data_next  = read_gated;
            rsp_index_next = idx_reg;
          end
          OP_SEARCH: begin
            if (cam_search_valid_i) begin
              rsp_hit_next   = 1'b1;
              rsp_index_next = cam_search_index_i;
            end
          end
          OP_INSERT: begin
            // Lookup-or-allocate: a hit returns the existing slot untouched.
            if (cam_search_valid_i) begin
              rsp_hit_next   = 1'b1;
              rsp_index_next = cam_search_index_i;
            end else begin
              state_next = ST_WRITE;
            end
          end
          default: begin
            rsp_err_next = 1'b1;
          end
        endcase
      end

      ST_WRITE: begin
        rsp_hit_next   = 1'b0;
        rsp_index_next = alloc_ptr_reg;
        rsp_data_next  = '0;
        rsp_evict_next = full;
        rsp_err_next   = 1'b0;
        // Pointer wraps naturally, giving oldest-first replacement once full.
        alloc_ptr_next = alloc_ptr_reg + IDX_W'(1);
        if (!full) begin
          alloc_cnt_next = alloc_cnt_reg + (IDX_W + 1)'(1);
        end
        state_next = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_READ;
      idx_reg       <= '0;
      key_reg       <= '0;
      rsp_hit_reg   <= 1'b0;
      rsp_index_reg <= '0;
      rsp_data_reg  <= '0;
      rsp_evict_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      alloc_ptr_reg <= '0;
      alloc_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      idx_reg       <= idx_next;
      key_reg       <= key_next;
      rsp_hit_reg   <= rsp_hit_next;
      rsp_index_reg <= rsp_index_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_evict_reg <= rsp_evict_next;
      rsp_err_reg   <= rsp_err_next;
      alloc_ptr_reg <= alloc_ptr_next;
      alloc_cnt_reg <= alloc_cnt_next;
    end
  end

  // Strobes decode straight from registered state, so each lasts one cycle.
  assign req_ready_o       = (state_reg == ST_IDLE);
  assign rsp_valid_o       = (state_reg == ST_RESP);
  assign rsp_hit_o         = rsp_hit_reg;
  assign rsp_index_o       = rsp_index_reg;
  assign rsp_data_o        = rsp_data_reg;
  assign rsp_evict_o       = rsp_evict_reg;
  assign rsp_err_o         = rsp_err_reg;
  assign full_o            = full;

  assign cam_read_o        = (state_reg == ST_ISSUE) && (op_reg == OP_READ);
  assign cam_read_index_o  = idx_reg;
  assign cam_search_o      = (state_reg == ST_ISSUE) && is_search_op;
  assign cam_search_data_o = key_reg;
  assign cam_write_o       = (state_reg == ST_WRITE);
  assign cam_write_index_o = alloc_ptr_reg;
  assign cam_write_data_o  = key_reg;

`ifdef CAM_CTRL_STATS_EN
  logic [15:0] stat_hits_reg;
  logic [15:0] stat_misses_reg;

  // A clear beats a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset_i || stat_clr_i) begin
      stat_hits_reg   <= '0;
      stat_misses_reg <= '0;
    end else if (cam_search_o) begin
      if (cam_search_valid_i) begin
        if (stat_hits_reg != 16'hFFFF) begin
          stat_hits_reg <= stat_hits_reg + 16'd1;
        end
      end else begin
        if (stat_misses_reg != 16'hFFFF) begin
          stat_misses_reg <= stat_misses_reg + 16'd1;
        end
      end
    end
  end

  assign stat_hits_o   = stat_hits_reg;
  assign stat_misses_o = stat_misses_reg;
`endif

endmodule

// File: tb/tb_cam_ctrl.sv
// Testbench for cam_ctrl: a behavioural CAM array stub plus a slot-level
// reference model of lookup-or-allocate with FIFO replacement.
module tb_cam_ctrl;

  localparam int DW = 32;
  localparam int IW = 5;
  localparam int NS = 32;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [1:0]    req_op_i = 2'b00;
  logic [IW-1:0] req_index_i = '0;
  logic [DW-1:0] req_data_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic          rsp_hit_o;
  logic [IW-1:0] rsp_index_o;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_evict_o;
  logic          rsp_err_o;
  logic          full_o;
  logic          cam_read_o;
  logic [IW-1:0] cam_read_index_o;
  logic          cam_write_o;
  logic [IW-1:0] cam_write_index_o;
  logic [DW-1:0] cam_write_data_o;
  logic          cam_search_o;
  logic [DW-1:0] cam_search_data_o;
  logic          cam_read_valid_i;
  logic [DW-1:0] cam_read_value_i;
  logic          cam_search_valid_i;
  logic [IW-1:0] cam_search_index_i;
`ifdef CAM_CTRL_STATS_EN
  logic          stat_clr_i = 1'b0;
  logic [15:0]   stat_hits_o;
  logic [15:0]   stat_misses_o;
`endif

  always #5 clk = ~clk;

  cam_ctrl dut (
    .clk                (clk),
    .reset_i            (reset_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_op_i           (req_op_i),
    .req_index_i        (req_index_i),
    .req_data_i         (req_data_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_hit_o          (rsp_hit_o),
    .rsp_index_o        (rsp_index_o),
    .rsp_data_o         (rsp_data_o),
    .rsp_evict_o        (rsp_evict_o),
    .rsp_err_o          (rsp_err_o),
    .full_o             (full_o),
    .cam_read_o         (cam_read_o),
    .cam_read_index_o   (cam_read_index_o),
    .cam_write_o        (cam_write_o),
    .cam_write_index_o  (cam_write_index_o),
    .cam_write_data_o   (cam_write_data_o),
    .cam_search_o       (cam_search_o),
    .cam_search_data_o  (cam_search_data_o),
    .cam_read_valid_i   (cam_read_valid_i),
    .cam_read_value_i   (cam_read_value_i),
    .cam_search_valid_i (cam_search_valid_i),
    .cam_search_index_i (cam_search_index_i)
`ifdef CAM_CTRL_STATS_EN
    ,
    .stat_clr_i         (stat_clr_i),
    .stat_hits_o        (stat_hits_o),
    .stat_misses_o      (stat_misses_o)
`endif
  );

  // CAM array stub: invalid entries hold random junk so read gating is exercised.
  logic [DW-1:0] cam_mem [NS];
  logic          cam_vld [NS];
  logic          cam_clr = 1'b0;

  always @(posedge clk) begin
    if (cam_clr) begin
      for (int i = 0; i < NS; i++) begin
        cam_mem[i] <= $urandom;
        cam_vld[i] <= 1'b0;
      end
    end else if (cam_write_o) begin
      cam_mem[cam_write_index_o] <= cam_write_data_o;
      cam_vld[cam_write_index_o] <= 1'b1;
    end
  end

  always_comb begin
    cam_read_valid_i   = 1'b0;
    cam_read_value_i   = '0;
    cam_search_valid_i = 1'b0;
    cam_search_index_i = '0;
    if (cam_read_o) begin
      cam_read_valid_i = cam_vld[cam_read_index_o];
      cam_read_value_i = cam_mem[cam_read_index_o];
    end
    if (cam_search_o) begin
      for (int i = NS - 1; i >= 0; i--) begin
        if (cam_vld[i] && cam_mem[i] == cam_search_data_o) begin
          cam_search_valid_i = 1'b1;
          cam_search_index_i = IW'(i);
        end
      end
    end
  end

  // Strobe monitor
  int rd_cnt = 0, sr_cnt = 0, wr_cnt = 0, onehot_bad = 0;
  always @(posedge clk) begin
    if (cam_read_o)   rd_cnt <= rd_cnt + 1;
    if (cam_search_o) sr_cnt <= sr_cnt + 1;
    if (cam_write_o)  wr_cnt <= wr_cnt + 1;
    if (int'(cam_read_o) + int'(cam_search_o) + int'(cam_write_o) > 1) onehot_bad <= onehot_bad + 1;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: slot contents, allocation pointer, allocations since reset.
  logic [DW-1:0] m_key [NS];
  bit            m_vld [NS];
  int            m_ptr, m_cnt;

  logic          e_hit, e_evict, e_err, e_full;
  logic [IW-1:0] e_idx;
  logic [DW-1:0] e_data;
  int            e_lat, e_rd, e_sr, e_wr;

  function automatic void model_reset(input bit clear_cam);
    m_ptr = 0;
    m_cnt = 0;
    if (clear_cam) for (int i = 0; i < NS; i++) m_vld[i] = 0;
  endfunction

  function automatic void predict(input logic [1:0] op, input logic [IW-1:0] idx, input logic [DW-1:0] key);
    int f;
    f = -1;
    for (int i = 0; i < NS; i++) if (f < 0 && m_vld[i] && m_key[i] == key) f = i;
    e_hit = 0; e_idx = '0; e_data = '0; e_evict = 0; e_err = 0;
    e_lat = 2; e_rd = 0; e_sr = 0; e_wr = 0;
    case (op)
      2'b00: begin
        e_rd   = 1;
        e_hit  = m_vld[idx];
        e_data = m_vld[idx] ? m_key[idx] : '0;
        e_idx  = idx;
      end
      2'b01: begin
        e_sr = 1;
        if (f >= 0) begin e_hit = 1; e_idx = IW'(f); end
      end
      2'b10: begin
        e_sr = 1;
        if (f >= 0) begin
          e_hit = 1; e_idx = IW'(f);
        end else begin
          e_lat = 3; e_wr = 1;
          e_idx = IW'(m_ptr);
          e_evict = (m_cnt == NS);
          m_key[m_ptr] = key;
          m_vld[m_ptr] = 1;
          m_ptr = (m_ptr + 1) % NS;
          if (m_cnt < NS) m_cnt++;
        end
      end
      default: e_err = 1;
    endcase
    e_full = (m_cnt == NS);
  endfunction

  function automatic logic [50:0] pack(input logic hit, input logic [IW-1:0] idx, input logic [DW-1:0] data,
                                       input logic ev, input logic err, input int lat, input int rd,
                                       input int sr, input int wr, input logic full);
    return {hit, idx, data, ev, err, 4'(lat), 2'(rd), 2'(sr), 2'(wr), full};
  endfunction

  // Observed results of the last transaction
  logic          o_hit, o_evict, o_err, o_full, o_after_valid;
  logic [IW-1:0] o_idx;
  logic [DW-1:0] o_data;
  int            o_lat, o_rd, o_sr, o_wr;
  int            hold_bad, ready_bad;

  task automatic send(input logic [1:0] op, input logic [IW-1:0] idx, input logic [DW-1:0] key,
                      input int hold, input bit keep_valid);
    int k, rd0, sr0, wr0;
    logic [39:0] snap;
    hold_bad = 0;
    ready_bad = 0;
    @(negedge clk);
    k = 0;
    while (!req_ready_o && k < 20) begin @(negedge clk); k++; end
    rd0 = rd_cnt; sr0 = sr_cnt; wr0 = wr_cnt;
    req_valid_i = 1'b1; req_op_i = op; req_index_i = idx; req_data_i = key;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!keep_valid) req_valid_i = 1'b0;
      else if (req_ready_o !== 1'b0) ready_bad++;
    end while (!rsp_valid_o && k < 20);
    o_lat = k;
    o_hit = rsp_hit_o; o_idx = rsp_index_o; o_data = rsp_data_o;
    o_evict = rsp_evict_o; o_err = rsp_err_o;
    snap = {rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_data_o, rsp_evict_o};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if ({rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_data_o, rsp_evict_o} !== snap || rsp_err_o !== o_err) hold_bad++;
      if (req_ready_o !== 1'b0) ready_bad++;
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    o_after_valid = rsp_valid_o;
    o_full = full_o;
    o_rd = rd_cnt - rd0; o_sr = sr_cnt - sr0; o_wr = wr_cnt - wr0;
    $display("txn op=%0d idx=%0d key=%h -> hit=%0d index=%0d data=%h evict=%0d err=%0d lat=%0d full=%0d",
             op, idx, key, o_hit, o_idx, o_data, o_evict, o_err, o_lat, o_full);
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    cam_clr = 1'b1;
    repeat (3) @(negedge clk);
    cam_clr = 1'b0;
    reset_i = 1'b0;
    model_reset(1);
    @(negedge clk);
    checks++;
    if ({req_ready_o, rsp_valid_o, full_o} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl got ready/valid/full=%b need 100", {req_ready_o, rsp_valid_o, full_o});
    end
    checks++;
    if ({cam_read_o, cam_search_o, cam_write_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes got %b need 000", {cam_read_o, cam_search_o, cam_write_o});
    end
    checks++;
    if ({rsp_hit_o, rsp_index_o, rsp_data_o, rsp_evict_o, rsp_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_rsp_fields got hit=%0d idx=%0d data=%h ev=%0d err=%0d need all 0",
               rsp_hit_o, rsp_index_o, rsp_data_o, rsp_evict_o, rsp_err_o);
    end
  endtask

  task automatic test_search_miss;
    predict(2'b01, '0, 32'hDEAD_BEEF);
    send(2'b01, '0, 32'hDEAD_BEEF, 0, 0);
    checks++;
    if (pack(o_hit, o_idx, o_data, o_evict, o_err, o_lat, o_rd, o_sr, o_wr, o_full) !==
        pack(e_hit, e_idx, e_data, e_evict, e_err, e_lat, e_rd, e_sr, e_wr, e_full)) begin
      errors++;
      $display("FAIL search_miss got hit=%0d idx=%0d lat=%0d wr=%0d need hit=%0d idx=%0d lat=%0d wr=%0d",
               o_hit, o_idx, o_lat, o_wr, e_hit, e_idx, e_lat, e_wr);
    end
  endtask

  task automatic test_insert_dup;
    for (int n = 0; n < 2; n++) begin
      predict(2'b10, '0, 32'h1234_5678);
      send(2'b10, '0, 32'h1234_5678, 0, 0);
      checks++;
      if (pack(o_hit, o_idx, o_data, o_evict, o_err, o_lat, o_rd, o_sr, o_wr, o_full) !==
          pack(e_hit, e_idx, e_data, e_evict, e_err, e_lat, e_rd, e_sr, e_wr, e_full)) begin
        errors++;
        $display("FAIL insert_dup%0d got hit=%0d idx=%0d lat=%0d wr=%0d ev=%0d need hit=%0d idx=%0d lat=%0d wr=%0d ev=%0d",
                 n, o_hit, o_idx, o_lat, o_wr, o_evict, e_hit, e_idx, e_lat, e_wr, e_evict);
      end
    end
    // alloc_ptr must still be 1: the next fresh key lands in slot 1
    predict(2'b10, '0, 32'h0BAD_F00D);
    send(2'b10, '0, 32'h0BAD_F00D, 0, 0);
    checks++;
    if (o_idx !== e_idx || o_wr !== e_wr) begin
      errors++;
      $display("FAIL alloc_after_dup got idx=%0d wr=%0d need idx=%0d wr=%0d", o_idx, o_wr, e_idx, e_wr);
    end
  endtask

  task automatic test_read;
    logic [IW-1:0] ri [2];
    ri[0] = 5'd0;
    ri[1] = 5'd5;
    for (int n = 0; n < 2; n++) begin
      predict(2'b00, ri[n], '0);
      send(2'b00, ri[n], '0, 0, 0);
      checks++;
      if (pack(o_hit, o_idx, o_data, o_evict, o_err, o_lat, o_rd, o_sr, o_wr, o_full) !==
          pack(e_hit, e_idx, e_data, e_evict, e_err, e_lat, e_rd, e_sr, e_wr, e_full)) begin
        errors++;
        $display("FAIL read_idx%0d got hit=%0d data=%h lat=%0d rd=%0d need hit=%0d data=%h lat=%0d rd=%0d",
                 ri[n], o_hit, o_data, o_lat, o_rd, e_hit, e_data, e_lat, e_rd);
      end
    end
  endtask

  task automatic test_fill_wrap;
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    model_reset(0);
    for (int k = 1; k <= 33; k++) begin
      predict(2'b10, '0, DW'(k));
      send(2'b10, '0, DW'(k), 0, 0);
      checks++;
      if (pack(o_hit, o_idx, o_data, o_evict, o_err, o_lat, o_rd, o_sr, o_wr, o_full) !==
          pack(e_hit, e_idx, e_data, e_evict, e_err, e_lat, e_rd, e_sr, e_wr, e_full)) begin
        errors++;
        $display("FAIL fill_key%0d got idx=%0d ev=%0d full=%0d wr=%0d need idx=%0d ev=%0d full=%0d wr=%0d",
                 k, o_idx, o_evict, o_full, o_wr, e_idx, e_evict, e_full, e_wr);
      end
    end
    predict(2'b01, '0, 32'd1);
    send(2'b01, '0, 32'd1, 0, 0);
    checks++;
    if (o_hit !== e_hit || o_idx !== e_idx) begin
      errors++;
      $display("FAIL evicted_key_search got hit=%0d idx=%0d need hit=%0d idx=%0d", o_hit, o_idx, e_hit, e_idx);
    end
  endtask

  task automatic test_backpressure;
    int extra_valid, s0;
    predict(2'b01, '0, 32'd20);
    send(2'b01, '0, 32'd20, 10, 1);
    checks++;
    if (pack(o_hit, o_idx, o_data, o_evict, o_err, o_lat, o_rd, o_sr, o_wr, o_full) !==
        pack(e_hit, e_idx, e_data, e_evict, e_err, e_lat, e_rd, e_sr, e_wr, e_full)) begin
      errors++;
      $display("FAIL bp_rsp got hit=%0d idx=%0d sr=%0d need hit=%0d idx=%0d sr=%0d", o_hit, o_idx, o_sr, e_hit, e_idx, e_sr);
    end
    checks++;
    if (hold_bad !== 0 || ready_bad !== 0) begin
      errors++;
      $display("FAIL bp_stable got unstable=%0d ready_high=%0d need 0 and 0", hold_bad, ready_bad);
    end
    s0 = rd_cnt + sr_cnt + wr_cnt;
    extra_valid = int'(o_after_valid);
    repeat (4) begin
      @(negedge clk);
      extra_valid += int'(rsp_valid_o);
    end
    checks++;
    if (extra_valid !== 0 || rd_cnt + sr_cnt + wr_cnt !== s0) begin
      errors++;
      $display("FAIL bp_single_rsp got extra_valid_cycles=%0d extra_strobes=%0d need 0 and 0",
               extra_valid, rd_cnt + sr_cnt + wr_cnt - s0);
    end
  endtask

  task automatic test_illegal;
    predict(2'b11, 5'd3, 32'hFFFF_0000);
    send(2'b11, 5'd3, 32'hFFFF_0000, 2, 0);
    checks++;
    if (pack(o_hit, o_idx, o_data, o_evict, o_err, o_lat, o_rd, o_sr, o_wr, o_full) !==
        pack(e_hit, e_idx, e_data, e_evict, e_err, e_lat, e_rd, e_sr, e_wr, e_full)) begin
      errors++;
      $display("FAIL illegal_op got err=%0d strobes=%0d/%0d/%0d lat=%0d need err=%0d strobes=0/0/0 lat=%0d",
               o_err, o_rd, o_sr, o_wr, o_lat, e_err, e_lat);
    end
  endtask

  task automatic test_reset_abort;
    int slot, seen;
    slot = m_ptr;
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = 2'b10; req_data_i = 32'hA5A5_0001;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (cam_write_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_write_phase got cam_write_o=%b need 1", cam_write_o);
    end
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    m_key[slot] = 32'hA5A5_0001;
    m_vld[slot] = 1;
    model_reset(0);
    @(negedge clk);
    checks++;
    if ({req_ready_o, full_o, rsp_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL abort_after_reset got ready/full/valid=%b need 100", {req_ready_o, full_o, rsp_valid_o});
    end
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen += int'(rsp_valid_o);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_rsp got valid_cycles=%0d need 0", seen);
    end
  endtask

  task automatic test_random;
    logic [1:0]    op;
    logic [IW-1:0] idx;
    logic [DW-1:0] key;
    int r;
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      idx = IW'($urandom_range(0, NS - 1));
      key = DW'($urandom_range(1, 48));
      predict(op, idx, key);
      send(op, idx, key, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      checks++;
      if (pack(o_hit, o_idx, o_data, o_evict, o_err, o_lat, o_rd, o_sr, o_wr, o_full) !==
          pack(e_hit, e_idx, e_data, e_evict, e_err, e_lat, e_rd, e_sr, e_wr, e_full) ||
          hold_bad !== 0 || ready_bad !== 0) begin
        errors++;
        $display("FAIL random%0d got %h unstable=%0d need %h",
                 n, pack(o_hit, o_idx, o_data, o_evict, o_err, o_lat, o_rd, o_sr, o_wr, o_full), hold_bad,
                 pack(e_hit, e_idx, e_data, e_evict, e_err, e_lat, e_rd, e_sr, e_wr, e_full));
      end
    end
    checks++;
    if (onehot_bad !== 0) begin
      errors++;
      $display("FAIL strobe_onehot got overlapping_cycles=%0d need 0", onehot_bad);
    end
  endtask

  initial begin
    test_reset();
    test_search_miss();
    test_insert_dup();
    test_read();
    test_fill_wrap();
    test_backpressure();
    test_illegal();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
